// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: steps a ROM address through NUM_PAT entries at a
// selectable rate, with run/pause, single-step, direction and blanking.
module led_seq_ctrl #(
    parameter int DIV_BASE = 5_000_000,
    parameter int NUM_PAT  = 18,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_run,
    input  logic              key_step,
    input  logic              dir,
    input  logic [1:0]        speed,
    output logic [ADDR_W-1:0] addr,
    output logic              led_en,
    output logic              wrap
);
    // One spare bit so DIV_BASE<<3 never overflows the counter
    localparam int CNT_W = $clog2(DIV_BASE * 8) + 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t            state;
    logic [1:0]        run_sync, step_sync;
    logic              run_prev, step_prev;
    logic              run_edge, step_edge;
    logic [CNT_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  period_m1;
    logic [ADDR_W-1:0] adv_addr;
    logic              adv_wrap;

    assign run_edge  = run_sync[1]  & ~run_prev;
    assign step_edge = step_sync[1] & ~step_prev;
    assign period_m1 = (CNT_W'(DIV_BASE) << speed) - CNT_W'(1);

    always_comb begin
        adv_wrap = 1'b0;
        adv_addr = addr;
        if (dir) begin
            adv_wrap = (addr == '0);
            adv_addr = adv_wrap ? ADDR_W'(NUM_PAT - 1) : addr - ADDR_W'(1);
        end else begin
            adv_wrap = (addr == ADDR_W'(NUM_PAT - 1));
            adv_addr = adv_wrap ? '0 : addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sync  <= '0;
            step_sync <= '0;
            run_prev  <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            run_sync  <= {run_sync[0], key_run};
            step_sync <= {step_sync[0], key_step};
            run_prev  <= run_sync[1];
            step_prev <= step_sync[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            div_cnt <= '0;
            led_en  <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (run_edge) begin
                        state  <= RUN;
                        led_en <= 1'b1;
                    end
                end
                RUN: begin
                    led_en <= 1'b1;
                    if (run_edge) begin
                        state <= PAUSE;
                    end else if (div_cnt >= period_m1) begin
                        // >= so a speed decrease past the count advances at once
                        div_cnt <= '0;
                        addr    <= adv_addr;
                        wrap    <= adv_wrap;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                PAUSE: begin
                    led_en <= 1'b1;
                    if (run_edge) begin
                        state <= RUN;
                    end else if (step_edge) begin
                        div_cnt <= '0;
                        addr    <= adv_addr;
                        wrap    <= adv_wrap;
                    end
                end
                default: begin
                    state  <= IDLE;
                    led_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: stimulus queues expected address changes,
// a monitor pops and checks them whenever addr moves.
module tb_led_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_run = 1'b0, key_step = 1'b0, dir = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [4:0] addr;
    logic       led_en, wrap;

    typedef struct {
        logic [4:0] a;
        logic       w;
        int         gap;   // expected cycles since previous change, 0 = don't care
    } exp_t;

    exp_t       sb[$];
    int         checks = 0, errors = 0;
    int         cyc = 0, last_cyc = 0;
    logic [4:0] last_addr = 5'd0;
    bit         mon_on = 1'b0;

    led_seq_ctrl #(.DIV_BASE(4), .NUM_PAT(18), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .key_run(key_run), .key_step(key_step),
        .dir(dir), .speed(speed), .addr(addr), .led_en(led_en), .wrap(wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int a, input int w, input int gap);
        exp_t e;
        e.a = 5'(a); e.w = w[0]; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic press(input logic r, input logic s);
        key_run = r; key_step = s;
        repeat (2) @(negedge clk);
        key_run = 1'b0; key_step = 1'b0;
    endtask

    // Monitor: every addr change must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (addr !== last_addr) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: addr=%0d wrap=%0b, expected no change from %0d",
                                 addr, wrap, last_addr);
                    end else begin
                        e = sb.pop_front();
                        if (addr !== e.a || wrap !== e.w || (e.gap != 0 && cyc - last_cyc != e.gap)) begin
                            errors++;
                            $display("FAIL step: addr=%0d wrap=%0b gap=%0d, expected addr=%0d wrap=%0b gap=%0d",
                                     addr, wrap, cyc - last_cyc, e.a, e.w, e.gap);
                        end
                    end
                    last_addr = addr;
                    last_cyc  = cyc;
                end else begin
                    checks++;
                    if (wrap !== 1'b0) begin
                        errors++;
                        $display("FAIL spurious_wrap: wrap=%0b at addr=%0d, expected 0", wrap, addr);
                    end
                end
            end
        end
    end

    initial begin
        // 1: reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_cyc = cyc;
        mon_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_addr", int'(addr), 0);
            chk("idle_led_en", int'(led_en), 0);
        end

        // 2: run forward at speed 0, full lap with wrap
        push(1, 0, 0);
        for (int a = 2; a < 18; a++) push(a, 0, 4);
        push(0, 1, 4);
        press(1'b1, 1'b0);
        @(negedge clk);
        chk("run_led_en", int'(led_en), 1);
        drain(200);

        // 3: reverse from 0 wraps to 17
        dir = 1'b1;
        push(17, 1, 4); push(16, 0, 4); push(15, 0, 4);
        drain(50);

        // 4: pause at 5, single steps, then run+step together
        for (int a = 14; a >= 5; a--) push(a, 0, 4);
        drain(100);
        press(1'b1, 1'b0);
        @(negedge clk);
        chk("pause_led_en", int'(led_en), 1);
        repeat (50) @(negedge clk);
        chk("pause_hold_addr", int'(addr), 5);
        dir = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(6 + k, 0, 0);
            press(1'b0, 1'b1);
            @(negedge clk);
            chk("step_addr", int'(addr), 6 + k);
            @(negedge clk);
        end
        push(9, 0, 0);
        press(1'b1, 1'b1);
        @(negedge clk);
        chk("run_wins_addr", int'(addr), 8);
        drain(20);

        // 5: slow speed, then drop speed mid-count
        speed = 2'd3;
        push(10, 0, 32);
        drain(100);
        push(11, 0, 21); push(12, 0, 4); push(13, 0, 4);
        repeat (20) @(negedge clk);
        speed = 2'd0;
        drain(50);

        // 6: async reset mid-run, then stays idle until run pressed
        for (int a = 14; a < 18; a++) push(a, 0, 4);
        push(0, 1, 4);
        for (int a = 1; a <= 9; a++) push(a, 0, 4);
        drain(200);
        push(0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_async_addr", int'(addr), 0);
        chk("rst_async_led_en", int'(led_en), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_rst_led_en", int'(led_en), 0);
        chk("post_rst_addr", int'(addr), 0);
        push(1, 0, 0);
        press(1'b1, 1'b0);
        @(negedge clk);
        chk("rerun_led_en", int'(led_en), 1);
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
